noc_pkt_injector: RTL and testbench

- Upstream injection stage feeding the NoC local input port (`flit_data_i` / `valid_i` / `vc_id_i` / `ready_o`).
- Takes a packet request (destination, size, VC, head data) plus a stream of payload words.
- Emits one HEAD flit, then BODY flits, then a TAIL flit, at up to one flit per cycle.
- A single registered output stage holds flit data stable until the router accepts it.

---
 rtl/noc_pkt_injector_pkg.sv | 35 +++
 rtl/noc_pkt_injector_if.sv | 42 ++++
 rtl/noc_pkt_injector_flit_out_reg.sv | 45 ++++
 rtl/noc_pkt_injector.sv | 123 ++++++++++++
 tb/tb_noc_pkt_injector.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkt_injector_pkg.sv
// Shared NoC definitions: flit types, field widths and the head flit layout.
package noc_pkt_injector_pkg;

    localparam int FLIT_DATA_W = 32;
    localparam int X_W         = 2;
    localparam int Y_W         = 2;
    localparam int PKT_W       = 8;
    localparam int N_VC        = 2;
    localparam int VC_W        = $clog2(N_VC);
    localparam int HEAD_DATA_W = FLIT_DATA_W - X_W - Y_W - PKT_W;
    localparam int FLIT_W      = FLIT_DATA_W + 2;

    // A request with this size is a single head-only packet.
    localparam logic [PKT_W-1:0] MIN_SIZE_FLIT = 8'd0;

    typedef enum logic [1:0] {
        HEAD_FLIT = 2'd0,
        BODY_FLIT = 2'd1,
        TAIL_FLIT = 2'd2
    } flit_type_t;

    typedef struct packed {
        flit_type_t              type_f;
        logic [X_W-1:0]          x_dest;
        logic [Y_W-1:0]          y_dest;
        logic [PKT_W-1:0]        pkt_size;
        logic [HEAD_DATA_W-1:0]  data;
    } s_flit_head_data_t;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } inj_state_t;

endpackage

// File: rtl/noc_pkt_injector_if.sv
// Injector bus: packet request, payload stream and the flit link to the router.
interface noc_pkt_injector_if;
    import noc_pkt_injector_pkg::*;

    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [X_W-1:0]          req_x_i;
    logic [Y_W-1:0]          req_y_i;
    logic [PKT_W-1:0]        req_size_i;
    logic [VC_W-1:0]         req_vc_i;
    logic [HEAD_DATA_W-1:0]  req_hdata_i;

    logic                    pld_valid_i;
    logic                    pld_ready_o;
    logic [FLIT_DATA_W-1:0]  pld_data_i;

    logic [FLIT_W-1:0]       flit_data_o;
    logic                    valid_o;
    logic [VC_W-1:0]         vc_id_o;
    logic                    ready_i;

    // The injector itself.
    modport master (
        input  req_valid_i, req_x_i, req_y_i, req_size_i, req_vc_i, req_hdata_i,
        output req_ready_o,
        input  pld_valid_i, pld_data_i,
        output pld_ready_o,
        output flit_data_o, valid_o, vc_id_o,
        input  ready_i
    );

    // The packet source and router side.
    modport slave (
        output req_valid_i, req_x_i, req_y_i, req_size_i, req_vc_i, req_hdata_i,
        input  req_ready_o,
        output pld_valid_i, pld_data_i,
        input  pld_ready_o,
        input  flit_data_o, valid_o, vc_id_o,
        output ready_i
    );

endinterface

// File: rtl/noc_pkt_injector_flit_out_reg.sv
// Single-entry valid/ready holding register driving the router input port.
module flit_out_reg
    import noc_pkt_injector_pkg::*;
(
    input  logic              clk,
    input  logic              arst,
    input  logic              load,
    input  logic [FLIT_W-1:0] load_flit,
    input  logic [VC_W-1:0]   load_vc,
    input  logic              out_ready,
    output logic [FLIT_W-1:0] flit,
    output logic              valid,
    output logic [VC_W-1:0]   vc,
    output logic              can_load
);

    logic [FLIT_W-1:0] flit_r;
    logic              valid_r;
    logic [VC_W-1:0]   vc_r;

    // Register is free when empty or when its current flit leaves this cycle.
    assign can_load = ~valid_r | out_ready;

    // Load a new flit, drop the old one on handshake, otherwise hold stable.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            flit_r  <= '0;
            valid_r <= 1'b0;
            vc_r    <= '0;
        end else if (load) begin
            flit_r  <= load_flit;
            valid_r <= 1'b1;
            vc_r    <= load_vc;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign flit  = flit_r;
    assign valid = valid_r;
    assign vc    = vc_r;

endmodule

// File: rtl/noc_pkt_injector.sv
// Packet injector: turns a request plus payload stream into HEAD/BODY/TAIL flits.
module noc_pkt_injector
    import noc_pkt_injector_pkg::*;
(
    input  logic               clk,
    input  logic               arst,
    noc_pkt_injector_if.master bus
);

    inj_state_t        state_r;
    logic [PKT_W-1:0]  cnt_r;

    logic              can_load_s;
    logic              req_ready_s;
    logic              pld_ready_s;
    logic              load_s;
    logic [FLIT_W-1:0] load_flit_s;
    logic [VC_W-1:0]   load_vc_s;
    s_flit_head_data_t head_s;

    logic [FLIT_W-1:0] flit_s;
    logic              valid_s;
    logic [VC_W-1:0]   vc_s;

    logic              req_hs_s;
    logic              pld_hs_s;

    // Readies are forced low while reset is asserted.
    assign req_hs_s = bus.req_valid_i & req_ready_s;
    assign pld_hs_s = bus.pld_valid_i & pld_ready_s;

    // Select which side may hand over data and build the flit to load.
    always_comb begin
        req_ready_s        = 1'b0;
        pld_ready_s        = 1'b0;
        load_s             = 1'b0;
        load_flit_s        = '0;
        load_vc_s          = vc_s;
        head_s.type_f      = HEAD_FLIT;
        head_s.x_dest      = bus.req_x_i;
        head_s.y_dest      = bus.req_y_i;
        head_s.pkt_size    = bus.req_size_i;
        head_s.data        = bus.req_hdata_i;
        case (state_r)
            IDLE: begin
                req_ready_s = can_load_s & arst;
                load_s      = bus.req_valid_i & can_load_s & arst;
                load_flit_s = head_s;
                load_vc_s   = bus.req_vc_i;
            end
            PAYLOAD: begin
                pld_ready_s = can_load_s & arst;
                load_s      = bus.pld_valid_i & can_load_s & arst;
                // VC is held from the head for the whole wormhole packet.
                load_vc_s   = vc_s;
                if (cnt_r == PKT_W'(1)) begin
                    load_flit_s = {TAIL_FLIT, bus.pld_data_i};
                end else begin
                    load_flit_s = {BODY_FLIT, bus.pld_data_i};
                end
            end
            default: begin
                req_ready_s = 1'b0;
                pld_ready_s = 1'b0;
            end
        endcase
    end

    // Packet FSM and remaining-flit counter; counter loads only with a nonzero size.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_hs_s && (bus.req_size_i != MIN_SIZE_FLIT)) begin
                        state_r <= PAYLOAD;
                        cnt_r   <= bus.req_size_i;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PAYLOAD: begin
                    if (pld_hs_s) begin
                        cnt_r <= cnt_r - PKT_W'(1);
                        if (cnt_r == PKT_W'(1)) begin
                            state_r <= IDLE;
                        end else begin
                            state_r <= PAYLOAD;
                        end
                    end else begin
                        state_r <= PAYLOAD;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    flit_out_reg u_flit_out_reg (
        .clk       (clk),
        .arst      (arst),
        .load      (load_s),
        .load_flit (load_flit_s),
        .load_vc   (load_vc_s),
        .out_ready (bus.ready_i),
        .flit      (flit_s),
        .valid     (valid_s),
        .vc        (vc_s),
        .can_load  (can_load_s)
    );

    assign bus.req_ready_o = req_ready_s;
    assign bus.pld_ready_o = pld_ready_s;
    assign bus.flit_data_o = flit_s;
    assign bus.valid_o     = valid_s;
    assign bus.vc_id_o     = vc_s;

endmodule

// File: tb/tb_noc_pkt_injector.sv
// Directed self-checking bench for noc_pkt_injector.
module tb_noc_pkt_injector;
    import noc_pkt_injector_pkg::*;

    logic clk;
    logic arst;
    int   checks_r;
    int   failures_r;

    noc_pkt_injector_if bus ();

    noc_pkt_injector dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_r = checks_r + 1;
        if (obs !== exp) begin
            failures_r = failures_r + 1;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [33:0] head_flit(input logic [1:0] x, input logic [1:0] y,
                                              input logic [7:0] sz, input logic [19:0] hd);
        return {2'b00, x, y, sz, hd};
    endfunction

    function automatic logic [33:0] pld_flit(input logic [1:0] t, input logic [31:0] d);
        return {t, d};
    endfunction

    task automatic check_flit(input string tag, input logic [33:0] f, input logic [0:0] vc);
        check_val({tag, "_valid"}, 64'(bus.valid_o), 64'd1);
        check_val({tag, "_data"}, 64'(bus.flit_data_o), 64'(f));
        check_val({tag, "_vc"}, 64'(bus.vc_id_o), 64'(vc));
    endtask

    task automatic send_req(input logic [1:0] x, input logic [1:0] y, input logic [7:0] sz,
                            input logic [0:0] vc, input logic [19:0] hd);
        bus.req_valid_i = 1'b1;
        bus.req_x_i     = x;
        bus.req_y_i     = y;
        bus.req_size_i  = sz;
        bus.req_vc_i    = vc;
        bus.req_hdata_i = hd;
    endtask

    initial begin
        logic [31:0] pl [3];
        checks_r        = 0;
        failures_r      = 0;
        arst            = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.req_x_i     = 2'd0;
        bus.req_y_i     = 2'd0;
        bus.req_size_i  = 8'd0;
        bus.req_vc_i    = 1'b0;
        bus.req_hdata_i = 20'd0;
        bus.pld_valid_i = 1'b0;
        bus.pld_data_i  = 32'd0;
        bus.ready_i     = 1'b1;

        // Reset state.
        tick();
        check_val("rst_valid", 64'(bus.valid_o), 64'd0);
        check_val("rst_data", 64'(bus.flit_data_o), 64'd0);
        check_val("rst_vc", 64'(bus.vc_id_o), 64'd0);
        check_val("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
        check_val("rst_pld_ready", 64'(bus.pld_ready_o), 64'd0);
        arst = 1'b1;
        tick();

        // Single-flit packet.
        send_req(2'd2, 2'd3, 8'd0, 1'b0, 20'hBEEF);
        #1;
        check_val("t1_req_ready", 64'(bus.req_ready_o), 64'd1);
        tick();
        bus.req_valid_i = 1'b0;
        check_flit("t1_head", 34'h0B000BEEF, 1'b0);
        check_val("t1_req_ready_after", 64'(bus.req_ready_o), 64'd1);
        tick();
        check_val("t1_drain", 64'(bus.valid_o), 64'd0);

        // Size 3 packet on VC1, no backpressure.
        pl[0] = 32'h11; pl[1] = 32'h22; pl[2] = 32'h33;
        send_req(2'd1, 2'd0, 8'd3, 1'b1, 20'h5);
        tick();
        bus.req_valid_i = 1'b0;
        check_flit("t2_head", head_flit(2'd1, 2'd0, 8'd3, 20'h5), 1'b1);
        for (int i = 0; i < 3; i++) begin
            bus.pld_valid_i = 1'b1;
            bus.pld_data_i  = pl[i];
            #1;
            check_val("t2_pld_ready", 64'(bus.pld_ready_o), 64'd1);
            check_val("t2_req_ready", 64'(bus.req_ready_o), 64'd0);
            tick();
            check_flit("t2_pld", pld_flit((i == 2) ? 2'd2 : 2'd1, pl[i]), 1'b1);
        end
        bus.pld_valid_i = 1'b0;
        tick();
        check_val("t2_drain", 64'(bus.valid_o), 64'd0);

        // Same packet with a 3-cycle stall while BODY 0x22 is on the link.
        send_req(2'd1, 2'd0, 8'd3, 1'b1, 20'h5);
        tick();
        bus.req_valid_i = 1'b0;
        check_flit("t3_head", head_flit(2'd1, 2'd0, 8'd3, 20'h5), 1'b1);
        bus.pld_valid_i = 1'b1;
        bus.pld_data_i  = 32'h11;
        tick();
        check_flit("t3_b11", pld_flit(2'd1, 32'h11), 1'b1);
        bus.pld_data_i = 32'h22;
        tick();
        check_flit("t3_b22", pld_flit(2'd1, 32'h22), 1'b1);
        bus.pld_data_i = 32'h33;
        bus.ready_i    = 1'b0;
        #1;
        check_val("t3_stall_pld_ready", 64'(bus.pld_ready_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_flit("t3_hold", pld_flit(2'd1, 32'h22), 1'b1);
            check_val("t3_hold_pld_ready", 64'(bus.pld_ready_o), 64'd0);
        end
        bus.ready_i = 1'b1;
        tick();
        check_flit("t3_tail", pld_flit(2'd2, 32'h33), 1'b1);
        bus.pld_valid_i = 1'b0;
        tick();
        check_val("t3_drain", 64'(bus.valid_o), 64'd0);

        // Back-to-back: size 1 on VC0 then head-only on VC1.
        send_req(2'd3, 2'd1, 8'd1, 1'b0, 20'hABCDE);
        tick();
        check_flit("t4_head0", head_flit(2'd3, 2'd1, 8'd1, 20'hABCDE), 1'b0);
        bus.req_valid_i = 1'b1;
        bus.req_size_i  = 8'd0;
        bus.req_vc_i    = 1'b1;
        bus.req_hdata_i = 20'h12345;
        bus.pld_valid_i = 1'b1;
        bus.pld_data_i  = 32'hAA;
        #1;
        check_val("t4_req_blocked", 64'(bus.req_ready_o), 64'd0);
        tick();
        check_flit("t4_tail", pld_flit(2'd2, 32'hAA), 1'b0);
        bus.pld_valid_i = 1'b0;
        #1;
        check_val("t4_req_ready", 64'(bus.req_ready_o), 64'd1);
        tick();
        bus.req_valid_i = 1'b0;
        check_flit("t4_head1", head_flit(2'd3, 2'd1, 8'd0, 20'h12345), 1'b1);
        tick();
        check_val("t4_drain", 64'(bus.valid_o), 64'd0);

        // Reset mid-packet after BODY 1 of a size-4 packet.
        send_req(2'd0, 2'd2, 8'd4, 1'b1, 20'h777);
        tick();
        bus.req_valid_i = 1'b0;
        check_flit("t5_head", head_flit(2'd0, 2'd2, 8'd4, 20'h777), 1'b1);
        bus.pld_valid_i = 1'b1;
        bus.pld_data_i  = 32'h1;
        tick();
        check_flit("t5_b1", pld_flit(2'd1, 32'h1), 1'b1);
        arst = 1'b0;
        #1;
        check_val("t5_rst_valid", 64'(bus.valid_o), 64'd0);
        check_val("t5_rst_data", 64'(bus.flit_data_o), 64'd0);
        check_val("t5_rst_vc", 64'(bus.vc_id_o), 64'd0);
        check_val("t5_rst_req_ready", 64'(bus.req_ready_o), 64'd0);
        check_val("t5_rst_pld_ready", 64'(bus.pld_ready_o), 64'd0);
        bus.pld_valid_i = 1'b0;
        tick();
        arst = 1'b1;
        #1;
        check_val("t5_req_ready", 64'(bus.req_ready_o), 64'd1);
        check_val("t5_pld_ready", 64'(bus.pld_ready_o), 64'd0);
        send_req(2'd1, 2'd1, 8'd0, 1'b1, 20'h42);
        tick();
        bus.req_valid_i = 1'b0;
        check_flit("t5_new_head", head_flit(2'd1, 2'd1, 8'd0, 20'h42), 1'b1);
        tick();
        check_val("t5_drain", 64'(bus.valid_o), 64'd0);

        // Payload offered in IDLE is ignored.
        bus.pld_valid_i = 1'b1;
        bus.pld_data_i  = 32'hDEAD;
        #1;
        check_val("t6_pld_ready", 64'(bus.pld_ready_o), 64'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("t6_no_flit", 64'(bus.valid_o), 64'd0);
        end
        bus.pld_valid_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
